// File: rtl/ru_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package ru_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NREGS    = 32;

  // One buffered slow-unit result: destination register and its value.
  typedef struct packed {
    logic [REG_AW-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/ru_wb_fifo.sv
// Synchronous FIFO of wb_req_t entries used to buffer slow-unit results.
// Pointers wrap modulo Depth (power of two); count is registered.
module ru_wb_fifo
  import ru_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  wb_req_t         wdata_i,
  input  logic            pop_i,
  output wb_req_t         rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  wb_req_t         mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d  = push_i ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop_i  ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

  a_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(push_i && !pop_i && full_o));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/ru_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, slow-unit
// results are buffered and force a one-cycle WB stall after STARVE_MAX waits.
// A per-register pending scoreboard drives decode hazard flags.
// Optional statistics outputs are enabled with RU_WB_ARB_STATS_EN.
module ru_wb_arbiter
  import ru_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8,
  localparam int unsigned CntW      = $clog2(DEPTH) + 1,
  localparam int unsigned StW       = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              wb_stall_o,
  input  logic              sl_valid_i,
  output logic              sl_ready_o,
  input  logic [REG_AW-1:0] sl_rd_i,
  input  logic [XLEN-1:0]   sl_data_i,
  input  logic              iss_valid_i,
  input  logic [REG_AW-1:0] iss_rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] dec_rd_i,
  output logic              busy_rs1_o,
  output logic              busy_rs2_o,
  output logic              busy_rd_o,
`ifdef RU_WB_ARB_STATS_EN
  output logic [31:0]       stat_stalls_o,
  output logic [31:0]       stat_fifo_full_o,
  output logic [CntW-1:0]   stat_max_occ_o,
`endif
  output logic              ru_write_o,
  output logic [REG_AW-1:0] ru_rd_o,
  output logic [XLEN-1:0]   ru_dw_o
);

  wb_req_t           push_req, head;
  logic [CntW-1:0]   count;
  logic              full, empty, push, pop, wb_go, iss_go;
  logic [StW-1:0]    starve_q, starve_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [REG_AW-1:0] last_rd_q;
  logic [XLEN-1:0]   last_dw_q;

  assign sl_ready_o = !rst_i && !full;
  assign push       = sl_valid_i && sl_ready_o && (sl_rd_i != '0);
  assign push_req   = '{rd: sl_rd_i, data: sl_data_i};
  assign wb_go      = wb_write_i && (wb_rd_i != '0);
  assign iss_go     = iss_valid_i && (iss_rd_i != '0);

  ru_wb_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (push_req),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Grant: forced drain, then pipeline, then opportunistic drain, else hold.
  // FIFO-side grants are suppressed under reset so buffered entries are discarded.
  always_comb begin
    wb_stall_o = !rst_i && !empty && (starve_q == StW'(STARVE_MAX));
    pop        = 1'b0;
    ru_write_o = 1'b0;
    ru_rd_o    = last_rd_q;
    ru_dw_o    = last_dw_q;
    if (wb_stall_o) begin
      pop        = 1'b1;
      ru_write_o = 1'b1;
      ru_rd_o    = head.rd;
      ru_dw_o    = head.data;
    end else if (wb_go) begin
      ru_write_o = 1'b1;
      ru_rd_o    = wb_rd_i;
      ru_dw_o    = wb_data_i;
    end else if (!rst_i && !empty) begin
      pop        = 1'b1;
      ru_write_o = 1'b1;
      ru_rd_o    = head.rd;
      ru_dw_o    = head.data;
    end
  end

  // Starvation and scoreboard next-state; an issue wins over a same-register clear.
  always_comb begin
    starve_d = starve_q;
    if (pop || empty) begin
      starve_d = '0;
    end else if (starve_q != StW'(STARVE_MAX)) begin
      starve_d = starve_q + StW'(1);
    end
    pending_d = pending_q;
    if (pop) begin
      pending_d[head.rd] = 1'b0;
    end
    if (iss_go) begin
      pending_d[iss_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Arbiter state registers; last driven rd/data are held while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q  <= '0;
      pending_q <= '0;
      last_rd_q <= '0;
      last_dw_q <= '0;
    end else begin
      starve_q  <= starve_d;
      pending_q <= pending_d;
      if (ru_write_o) begin
        last_rd_q <= ru_rd_o;
        last_dw_q <= ru_dw_o;
      end
    end
  end

  assign busy_rs1_o = pending_q[rs1_i];
  assign busy_rs2_o = pending_q[rs2_i];
  assign busy_rd_o  = pending_q[dec_rd_i];

`ifdef RU_WB_ARB_STATS_EN
  logic [31:0]     stat_stalls_q, stat_fifo_full_q;
  logic [CntW-1:0] stat_max_occ_q;

  // Event counters (wrapping) and occupancy high-water mark.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_stalls_q    <= '0;
      stat_fifo_full_q <= '0;
      stat_max_occ_q   <= '0;
    end else begin
      if (wb_stall_o) stat_stalls_q <= stat_stalls_q + 32'd1;
      if (sl_valid_i && !sl_ready_o) stat_fifo_full_q <= stat_fifo_full_q + 32'd1;
      if (count > stat_max_occ_q) stat_max_occ_q <= count;
    end
  end

  assign stat_stalls_o    = stat_stalls_q;
  assign stat_fifo_full_o = stat_fifo_full_q;
  assign stat_max_occ_o   = stat_max_occ_q;
`endif

  a_iss_not_pending: assert property (@(posedge clk_i) disable iff (rst_i)
                                      !(iss_go && pending_q[iss_rd_i]));
  a_wb_not_pending:  assert property (@(posedge clk_i) disable iff (rst_i)
                                      !(wb_go && !wb_stall_o && pending_q[wb_rd_i]));

endmodule

// File: tb/tb_ru_wb_arbiter.sv
// Directed self-checking bench for ru_wb_arbiter (DEPTH=4, STARVE_MAX=8).
module tb_ru_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_write, sl_valid, iss_valid;
  logic [4:0]  wb_rd, sl_rd, iss_rd, rs1, rs2, dec_rd;
  logic [31:0] wb_data, sl_data;
  logic        wb_stall, sl_ready, busy_rs1, busy_rs2, busy_rd, ru_write;
  logic [4:0]  ru_rd;
  logic [31:0] ru_dw;
`ifdef RU_WB_ARB_STATS_EN
  logic [31:0] stat_stalls, stat_fifo_full;
  logic [2:0]  stat_max_occ;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ru_wb_arbiter #(
    .XLEN       (32),
    .DEPTH      (4),
    .STARVE_MAX (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wb_write_i  (wb_write),
    .wb_rd_i     (wb_rd),
    .wb_data_i   (wb_data),
    .wb_stall_o  (wb_stall),
    .sl_valid_i  (sl_valid),
    .sl_ready_o  (sl_ready),
    .sl_rd_i     (sl_rd),
    .sl_data_i   (sl_data),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .dec_rd_i    (dec_rd),
    .busy_rs1_o  (busy_rs1),
    .busy_rs2_o  (busy_rs2),
    .busy_rd_o   (busy_rd),
`ifdef RU_WB_ARB_STATS_EN
    .stat_stalls_o    (stat_stalls),
    .stat_fifo_full_o (stat_fifo_full),
    .stat_max_occ_o   (stat_max_occ),
`endif
    .ru_write_o  (ru_write),
    .ru_rd_o     (ru_rd),
    .ru_dw_o     (ru_dw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wb_write = 1'b0; sl_valid = 1'b0; iss_valid = 1'b0;
    wb_rd = '0; sl_rd = '0; iss_rd = '0; wb_data = '0; sl_data = '0;
    rs1 = 5'd1; rs2 = 5'd2; dec_rd = 5'd3;

    // 1. Reset, then idle.
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_sl_ready", sl_ready, 0);
    nxt();
    rst = 1'b0;
    settle();
    chk("idle_ru_write", ru_write, 0);
    chk("idle_sl_ready", sl_ready, 1);
    chk("idle_busy_rs1", busy_rs1, 0);
    chk("idle_busy_rs2", busy_rs2, 0);
    chk("idle_busy_rd", busy_rd, 0);
    chk("idle_wb_stall", wb_stall, 0);
    nxt();

    // 2. Issue rd5, slow result to rd5, written the cycle after accept.
    iss_valid = 1'b1; iss_rd = 5'd5; rs1 = 5'd5;
    settle();
    chk("t2_busy_pre", busy_rs1, 0);
    nxt();
    iss_valid = 1'b0; sl_valid = 1'b1; sl_rd = 5'd5; sl_data = 32'hDEAD_BEEF;
    settle();
    chk("t2_busy_set", busy_rs1, 1);
    chk("t2_no_bypass", ru_write, 0);
    nxt();
    sl_valid = 1'b0;
    settle();
    chk("t2_wr", ru_write, 1);
    chk("t2_rd", ru_rd, 5);
    chk("t2_dw", ru_dw, 32'hDEAD_BEEF);
    chk("t2_busy_still", busy_rs1, 1);
    nxt();
    settle();
    chk("t2_busy_clr", busy_rs1, 0);
    chk("t2_idle", ru_write, 0);
    chk("t2_hold_rd", ru_rd, 5);
    chk("t2_hold_dw", ru_dw, 32'hDEAD_BEEF);
    nxt();

    // 3. Continuous pipeline WB; one slow result to rd7 forces a stall.
    wb_write = 1'b1; wb_rd = 5'd1; wb_data = 32'h100;
    sl_valid = 1'b1; sl_rd = 5'd7; sl_data = 32'h77;
    settle();
    chk("t3_first_rd", ru_rd, 1);
    chk("t3_first_stall", wb_stall, 0);
    nxt();
    sl_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wb_rd = 5'(i + 1); wb_data = 32'h100 + 32'(i);
      settle();
      chk("t3_wait_stall", wb_stall, 0);
      chk("t3_wait_rd", ru_rd, 32'(i + 1));
      nxt();
    end
    wb_rd = 5'd10; wb_data = 32'h10A;
    settle();
    chk("t3_stall", wb_stall, 1);
    chk("t3_stall_wr", ru_write, 1);
    chk("t3_stall_rd", ru_rd, 7);
    chk("t3_stall_dw", ru_dw, 32'h77);
    nxt();
    wb_rd = 5'd11; wb_data = 32'h10B;
    settle();
    chk("t3_after_stall", wb_stall, 0);
    chk("t3_after_rd", ru_rd, 11);
    nxt();

    // 4. Five back-to-back slow results under continuous pipeline WB.
    wb_rd = 5'd1; wb_data = 32'h11;
    for (int k = 0; k < 4; k++) begin
      sl_valid = 1'b1; sl_rd = 5'(11 + k); sl_data = 32'hA0 + 32'(k);
      settle();
      chk("t4_ready", sl_ready, 1);
      chk("t4_wb_rd", ru_rd, 1);
      nxt();
    end
    sl_rd = 5'd15; sl_data = 32'hA4;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t4_full", sl_ready, 0);
      chk("t4_no_stall", wb_stall, 0);
      nxt();
    end
    settle();
    chk("t4_stall", wb_stall, 1);
    chk("t4_stall_rd", ru_rd, 11);
    chk("t4_stall_dw", ru_dw, 32'hA0);
    chk("t4_stall_full", sl_ready, 0);
    nxt();
    settle();
    chk("t4_5th_ready", sl_ready, 1);
    chk("t4_5th_stall", wb_stall, 0);
    chk("t4_5th_wb", ru_rd, 1);
    nxt();
    sl_valid = 1'b0; wb_write = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("t4_drain_wr", ru_write, 1);
      chk("t4_drain_rd", ru_rd, 32'(11 + k));
      chk("t4_drain_dw", ru_dw, 32'hA0 + 32'(k));
      nxt();
    end
    settle();
    chk("t4_empty", ru_write, 0);
    nxt();

    // 5. sl_rd=0 is dropped; wb_rd=0 is an idle slot the FIFO may use.
    sl_valid = 1'b1; sl_rd = 5'd0; sl_data = 32'h55;
    settle();
    chk("t5_ready", sl_ready, 1);
    nxt();
    sl_valid = 1'b0;
    settle();
    chk("t5_dropped", ru_write, 0);
    nxt();
    sl_valid = 1'b1; sl_rd = 5'd9; sl_data = 32'h99;
    wb_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    settle();
    chk("t5_wb_rd", ru_rd, 3);
    nxt();
    sl_valid = 1'b0; wb_rd = 5'd0;
    settle();
    chk("t5_x0_wr", ru_write, 1);
    chk("t5_x0_rd", ru_rd, 9);
    chk("t5_x0_dw", ru_dw, 32'h99);
    nxt();
    wb_write = 1'b0;
    settle();
    chk("t5_idle", ru_write, 0);
    chk("t5_hold_dw", ru_dw, 32'h99);
    nxt();

    // 6. Reset mid-drain with three queued entries and pending bits.
    iss_valid = 1'b1; iss_rd = 5'd10;
    nxt();
    iss_rd = 5'd11;
    nxt();
    iss_rd = 5'd12;
    nxt();
    iss_valid = 1'b0;
    wb_write = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
    for (int k = 0; k < 3; k++) begin
      sl_valid = 1'b1; sl_rd = 5'(10 + k); sl_data = 32'hC0 + 32'(k);
      nxt();
    end
    sl_valid = 1'b0; rs1 = 5'd10; rs2 = 5'd11; dec_rd = 5'd12;
    settle();
    chk("t6_busy_rs1", busy_rs1, 1);
    chk("t6_busy_rs2", busy_rs2, 1);
    chk("t6_busy_rd", busy_rd, 1);
    chk("t6_wb_rd", ru_rd, 2);
    nxt();
    rst = 1'b1; wb_write = 1'b0;
    settle();
    chk("t6_rst_wr", ru_write, 0);
    chk("t6_rst_ready", sl_ready, 0);
    nxt();
    rst = 1'b0;
    settle();
    chk("t6_post_wr", ru_write, 0);
    chk("t6_post_rs1", busy_rs1, 0);
    chk("t6_post_rs2", busy_rs2, 0);
    chk("t6_post_rd", busy_rd, 0);
    chk("t6_post_stall", wb_stall, 0);
    chk("t6_post_ready", sl_ready, 1);
    nxt();
    settle();
    chk("t6_no_stale", ru_write, 0);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
